// File: rtl/audio_pwm_out.sv
// Audio output stage: volume-scaled sample pipeline feeding a 1-bit PWM pin, plus sample pacing.
// Optional SOFT_MUTE_EN: level_out slews by one step per PWM period toward the pending level.
module audio_pwm_out #(
    parameter int unsigned SAMPLE_DIV = 256,
    parameter int unsigned PWM_BITS   = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] sample_in,
    input  logic [3:0] volume1,
    input  logic [3:0] volume0,
    input  logic       play,
    output logic       sample_req,
    output logic       pwm_out,
    output logic [7:0] level_out
);

    localparam int unsigned DivW = $clog2(SAMPLE_DIV);
    localparam int unsigned CmpW = (PWM_BITS > 8) ? PWM_BITS : 8;

    logic [DivW-1:0]     div_cnt_q, div_cnt_d;
    logic                req_q, req_d;
    logic                s1_vld_q, s2_vld_q;
    logic signed [8:0]   s1_sample_q, s1_sample_d;
    logic [6:0]          s1_vol_q;
    logic signed [15:0]  prod_q, prod_d;
    logic [7:0]          pending_q, pending_d;
    logic [PWM_BITS-1:0] pwm_cnt_q;
    logic                pwm_q, pwm_d;
    logic [7:0]          level_q, level_d;

    logic [3:0]          dig1, dig0;
    logic [6:0]          vol_dec;
    logic signed [22:0]  scaled, shifted, biased;
    logic [7:0]          sat_level;
    logic                div_last, pwm_wrap;

    // Sample divider; the registered strobe makes the first pulse land SAMPLE_DIV cycles out.
    always_comb begin
        div_last  = (div_cnt_q == DivW'(SAMPLE_DIV - 1));
        div_cnt_d = div_last ? '0 : div_cnt_q + 1'b1;
        req_d     = div_last;
    end

    always_comb begin
        dig1    = (volume1 > 4'd9) ? 4'd9 : volume1;
        dig0    = (volume0 > 4'd9) ? 4'd9 : volume0;
        vol_dec = ({3'b000, dig1} << 3) + ({3'b000, dig1} << 1) + {3'b000, dig0};
    end

    always_comb begin
        s1_sample_d = $signed({1'b0, sample_in}) - 9'sd128;
        prod_d      = 16'(s1_sample_q) * 16'($signed({1'b0, s1_vol_q}));
    end

    // (p * 41) >>> 12 approximates p / 100 with floor toward -inf.
    always_comb begin
        scaled  = 23'(prod_q) * 23'sd41;
        shifted = scaled >>> 12;
        biased  = shifted + 23'sd128;
        if (biased < 23'sd0) begin
            sat_level = 8'd0;
        end else if (biased > 23'sd255) begin
            sat_level = 8'd255;
        end else begin
            sat_level = biased[7:0];
        end
        pending_d = pending_q;
        if (s2_vld_q) begin
            pending_d = play ? sat_level : 8'd128;
        end
    end

    always_comb begin
        pwm_wrap = &pwm_cnt_q;
        pwm_d    = (CmpW'(pwm_cnt_q) < CmpW'(level_q));
        level_d  = level_q;
`ifdef SOFT_MUTE_EN
        if (pwm_wrap) begin
            if (level_q < pending_q) begin
                level_d = level_q + 8'd1;
            end else if (level_q > pending_q) begin
                level_d = level_q - 8'd1;
            end
        end
`else
        if (pwm_wrap) begin
            level_d = pending_q;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt_q   <= '0;
            req_q       <= 1'b0;
            s1_vld_q    <= 1'b0;
            s2_vld_q    <= 1'b0;
            s1_sample_q <= '0;
            s1_vol_q    <= '0;
            prod_q      <= '0;
            pending_q   <= 8'd128;
            pwm_cnt_q   <= '0;
            pwm_q       <= 1'b0;
            level_q     <= 8'd128;
        end else begin
            div_cnt_q <= div_cnt_d;
            req_q     <= req_d;
            s1_vld_q  <= req_q;
            s2_vld_q  <= s1_vld_q;
            if (req_q) begin
                s1_sample_q <= s1_sample_d;
                s1_vol_q    <= vol_dec;
            end
            if (s1_vld_q) begin
                prod_q <= prod_d;
            end
            pending_q <= pending_d;
            pwm_cnt_q <= pwm_cnt_q + 1'b1;
            pwm_q     <= pwm_d;
            level_q   <= level_d;
        end
    end

    assign sample_req = req_q;
    assign pwm_out    = pwm_q;
    assign level_out  = level_q;

endmodule

// File: tb/tb_audio_pwm_out.sv
// Bench for audio_pwm_out: expected PWM levels are queued per PWM period and checked by a monitor.
// Define SOFT_MUTE_EN to exercise the slewing build instead of the directed vector set.
module tb_audio_pwm_out;

    localparam int SD  = 256;
    localparam int PER = 256;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] sample_in = 8'd128;
    logic [3:0] volume1 = 4'd0;
    logic [3:0] volume0 = 4'd0;
    logic       play = 1'b0;
    logic       sample_req;
    logic       pwm_out;
    logic [7:0] level_out;

    audio_pwm_out #(
        .SAMPLE_DIV(SD),
        .PWM_BITS  (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .sample_in (sample_in),
        .volume1   (volume1),
        .volume0   (volume0),
        .play      (play),
        .sample_req(sample_req),
        .pwm_out   (pwm_out),
        .level_out (level_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        int m;
        int lvl;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail = 0;
    int   cyc = 0;

    task automatic check(input string name, input int act, input int expv);
        n_tests++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Monitor: one PWM period spans the outputs of edges 256m+1 .. 256m+256 after release.
    int   hi, lvl0, idx, mper;
    bit   stable, win_ok, prev_req;
    exp_t e;

    always @(posedge clk) begin
        #1;
        if (reset) begin
            cyc      = 0;
            win_ok   = 1'b0;
            prev_req = 1'b0;
        end else begin
            cyc++;
            if (sample_req) begin
                check("req_spacing", cyc % SD, 0);
                check("req_width", int'(prev_req), 0);
            end
            prev_req = sample_req;
            idx = (cyc - 1) % PER;
            if (idx == 0) begin
                hi     = 0;
                lvl0   = int'(level_out);
                stable = 1'b1;
                win_ok = 1'b1;
            end
            if (pwm_out) hi++;
            if (idx <= PER - 2 && int'(level_out) != lvl0) stable = 1'b0;
            if (idx == PER - 1 && win_ok) begin
                mper = (cyc - 1) / PER;
                while (sb.size() > 0 && sb[0].m < mper) begin
                    e = sb.pop_front();
                    n_tests++;
                    n_fail++;
                    $display("FAIL missed_period: got no window, expected period %0d level %0d",
                             e.m, e.lvl);
                end
                if (sb.size() > 0 && sb[0].m == mper) begin
                    e = sb.pop_front();
                    check("level_out", lvl0, e.lvl);
                    check("pwm_high_count", hi, e.lvl);
                    check("level_stable", int'(stable), 1);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_req(output int k, output bit ok);
        ok = 1'b0;
        k  = 0;
        for (int i = 0; i < SD + 300; i++) begin
            step();
            if (sample_req) begin
                k  = cyc;
                ok = 1'b1;
                return;
            end
        end
        n_tests++;
        n_fail++;
        $display("FAIL wait_req: got no sample_req, expected one within %0d cycles", SD + 300);
    endtask

    task automatic run_vec(input logic [3:0] v1, input logic [3:0] v0, input logic [7:0] s,
                           input logic p, input int exp_lvl);
        int k;
        bit ok;
        volume1   = v1;
        volume0   = v0;
        sample_in = s;
        play      = p;
        wait_req(k, ok);
        // Pending lands 3 edges after the strobe; the next wrap at or after k+4 loads it.
        if (ok) sb.push_back('{m: (k + 3) / PER + 1, lvl: exp_lvl});
        repeat (3) step();
    endtask

    task automatic drain(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (sb.size() == 0) break;
            step();
        end
        check("scoreboard_drained", sb.size(), 0);
    endtask

    task automatic wait_level(input int lvl, input int budget, input string name);
        bit found;
        found = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (int'(level_out) == lvl) begin
                found = 1'b1;
                break;
            end
            step();
        end
        check(name, int'(level_out), lvl);
    endtask

    initial begin
        int  k;
        bit  ok;
        reset = 1'b1;
        sb.push_back('{m: 0, lvl: 128});
        repeat (3) step();
        check("reset_level", int'(level_out), 128);
        check("reset_pwm", int'(pwm_out), 0);
        check("reset_req", int'(sample_req), 0);
        reset = 1'b0;

`ifndef SOFT_MUTE_EN
        run_vec(4'd9, 4'd9, 8'd255, 1'b1, 253);
        run_vec(4'd5, 4'd0, 8'd0,   1'b1, 63);
        run_vec(4'd0, 4'd0, 8'd17,  1'b1, 128);
        run_vec(4'd9, 4'd9, 8'd17,  1'b0, 128);
        run_vec(4'hF, 4'hC, 8'd255, 1'b1, 253);
        run_vec(4'd1, 4'd2, 8'd200, 1'b1, 136);
        run_vec(4'd3, 4'd7, 8'd100, 1'b1, 117);
        run_vec(4'hA, 4'd5, 8'd1,   1'b1, 7);
        run_vec(4'd9, 4'd9, 8'd0,   1'b1, 1);
        drain(3 * PER);

        // Reset just after a capture: the in-flight sample must never reach level_out.
        volume1   = 4'd9;
        volume0   = 4'd9;
        sample_in = 8'd255;
        play      = 1'b1;
        wait_req(k, ok);
        step();
        reset = 1'b1;
        step();
        check("midreset_level", int'(level_out), 128);
        check("midreset_pwm", int'(pwm_out), 0);
        check("midreset_req", int'(sample_req), 0);
        step();
        reset = 1'b0;
        sb.push_back('{m: 0, lvl: 128});
        sb.push_back('{m: 1, lvl: 128});
        sb.push_back('{m: 2, lvl: 253});
        drain(4 * PER);
`else
        volume1   = 4'd9;
        volume0   = 4'd9;
        sample_in = 8'd255;
        play      = 1'b1;
        repeat (33000) step();
        check("soft_ramp_top", int'(level_out), 253);
        play = 1'b0;
        wait_level(252, 2 * PER, "soft_first_step");
        repeat (PER) step();
        check("soft_second_step", int'(level_out), 251);
        wait_level(128, 130 * PER, "soft_reach_128");
        play = 1'b1;
        repeat (20 * PER) step();
        check("soft_mid_ramp", int'(level_out > 8'd128 && level_out < 8'd253), 1);
        reset = 1'b1;
        step();
        check("soft_reset_level", int'(level_out), 128);
        reset = 1'b0;
        step();
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
